frame_buffer_filler: RTL
========================

Name: frame_buffer_filler

Overview:
- Sequential writer that paints solid-colour rectangles into the dual-port frame buffer through its write port (address, data, write-enable).
- Sits between the control logic (buttons, game FSM, pattern generator) and the buffer's write side.
- The VGA scan-out continues to read the buffer independently on the other port.
- Writes one pixel per clock using a raster order (row-major, left to right, top to bottom).

Parameters:
- AW, 15, buffer address width in bits.
- DW, 12, pixel data width in bits (RGB444).
- H_RES, 160, frame width in pixels.
- V_RES, 120, frame height in pixels.
- CW, 8, width of each coordinate and size field.

Ports:
- clk  in  1  single system clock; also drives the buffer write clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  command strobe; sampled only while busy=0.
- x0  in  CW  left column of the rectangle.
- y0  in  CW  top row of the rectangle.
- w  in  CW  width in pixels.
- h  in  CW  height in pixels.
- color  in  DW  fill colour.
- buf_addr  out  AW  write address to the buffer.
- buf_data  out  DW  write data to the buffer.
- buf_we  out  1  write enable to the buffer.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE.
  - buf_addr=0, buf_data=0, buf_we=0, busy=0, done=0.
  - All latched fields and counters are cleared.
  - A fill in progress is abandoned; no further writes occur after reset is released.
- States: IDLE, SETUP, FILL, DONE. All outputs are registered.
- IDLE:
  - busy=0, buf_we=0.
  - start=1 latches x0, y0, w, h and color, then moves to SETUP.
- SETUP (1 cycle):
  - busy=1.
  - Computes the effective width/height (see the Optional Feature section).
  - Computes the first-row base as y0*H_RES by repeated addition over the latched data, or equivalent logic that meets timing in one cycle; no multiplier is inferred on the addr path in FILL.
  - If effective width or height is 0, goes to DONE with no writes; otherwise goes to FILL.
- FILL:
  - Each cycle: buf_we=1, buf_addr=row_base+x0+col, buf_data=latched color.
  - col increments each cycle.
  - At col=eff_w-1: col wraps to 0, row increments, and row_base increases by H_RES.
  - After the write at (eff_w-1, eff_h-1), goes to DONE.
- DONE (1 cycle):
  - done=1, busy=1, buf_we=0.
  - Then returns to IDLE, where busy=0.
- Timing: with start sampled at cycle N:
  - SETUP occurs at N+1.
  - Writes occur on cycles N+2 through N+1+eff_w*eff_h.
  - done pulses at N+2+eff_w*eff_h.
- start while busy=1 is ignored and is not queued.
- start held high across DONE→IDLE launches a new command on the first IDLE cycle.
- Inputs x0/y0/w/h/color may change freely after acceptance.
- Address arithmetic is AW bits wide; the maximum in-frame address is 19199, which fits in 15 bits.
- Exactly one write per pixel; no pixel is written twice.

Optional Feature:
- Macro: FILLER_CLIP_EN.
- Defined:
  - If x0>=H_RES or y0>=V_RES, eff_w=eff_h=0 and the command completes with no writes.
  - Otherwise eff_w=min(w, H_RES-x0) and eff_h=min(h, V_RES-y0).
  - No write ever falls outside the frame.
- Undefined:
  - eff_w=w and eff_h=h with no checks.
  - Out-of-frame coordinates produce addresses computed modulo 2^AW (writes wrap into other rows or unused RAM).
  - The caller is responsible for staying in range.
  - Saves the comparators and subtractors.

Test Plan:
- Reset at rest: reset=0 then 1 → all outputs 0, state IDLE, no buf_we for 10 cycles.
- Basic fill: start with x0=2, y0=1, w=3, h=2, color=12'hF00 → 6 writes of 12'hF00 to addresses 162, 163, 164, 322, 323, 324 on consecutive cycles N+2..N+7; done=1 at N+8; busy=0 at N+9.
- Zero size and ignored start: w=0, h=5 → no writes, done at N+2. Then start pulsed during a 4x4 fill → ignored; exactly 16 writes.
- Clipping (FILLER_CLIP_EN defined): x0=158, y0=119, w=5, h=5, color=12'h0F0 → writes only to 19198 and 19199, then done. With x0=200 → no writes, done at N+2.
- Reset mid-fill: 10x10 fill, reset=0 after 37 writes → buf_we, busy and done drop immediately (asynchronously). After release, no writes until a new start; a new 1x1 fill at (0,0) writes address 0 only.
- Back-to-back: start held high → second command accepted on the cycle after DONE; full-frame fill (0,0,160,120) produces 19200 writes, with the last at address 19199.

Source files
------------

// File: rtl/frame_buffer_filler.sv
// Paints a solid rectangle into the frame buffer write port, one pixel per clock in raster order; FILLER_CLIP_EN clips the rectangle to the frame.
// Latency: start -> SETUP (1) -> eff_w*eff_h write cycles -> done pulse, so done comes 2+eff_w*eff_h cycles after start.
// Backpressure: none; start is ignored while busy and the buffer must accept a write every cycle.
module frame_buffer_filler #(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int H_RES = 160,
    parameter int V_RES = 120,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] x0,
    input  logic [CW-1:0] y0,
    input  logic [CW-1:0] w,
    input  logic [CW-1:0] h,
    input  logic [DW-1:0] color,
    output logic [AW-1:0] buf_addr,
    output logic [DW-1:0] buf_data,
    output logic          buf_we,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] x0_q, y0_q, w_q, h_q, x0_n, y0_n, w_n, h_n;
    logic [DW-1:0] color_q, color_n, buf_data_n;
    logic [CW-1:0] eff_w_q, eff_h_q, eff_w_n, eff_h_n, eff_w_calc, eff_h_calc;
    logic [CW-1:0] col, row, col_n, row_n;
    logic [AW-1:0] row_base, row_base_n, buf_addr_n;
    logic          buf_we_n, busy_n, done_n;

`ifdef FILLER_CLIP_EN
    localparam logic [CW-1:0] H_LIM = CW'(H_RES);
    localparam logic [CW-1:0] V_LIM = CW'(V_RES);
    logic [CW-1:0] x_room, y_room;

    // Room to the frame edge is only meaningful once the origin is known to be inside.
    always_comb begin
        x_room     = H_LIM - x0_q;
        y_room     = V_LIM - y0_q;
        eff_w_calc = '0;
        eff_h_calc = '0;
        if ((x0_q < H_LIM) && (y0_q < V_LIM)) begin
            eff_w_calc = (w_q < x_room) ? w_q : x_room;
            eff_h_calc = (h_q < y_room) ? h_q : y_room;
        end
    end
`else
    assign eff_w_calc = w_q;
    assign eff_h_calc = h_q;
`endif

    always_comb begin
        state_n    = state;
        x0_n       = x0_q;
        y0_n       = y0_q;
        w_n        = w_q;
        h_n        = h_q;
        color_n    = color_q;
        eff_w_n    = eff_w_q;
        eff_h_n    = eff_h_q;
        col_n      = col;
        row_n      = row;
        row_base_n = row_base;
        buf_addr_n = buf_addr;
        buf_data_n = buf_data;
        case (state)
            IDLE: begin
                if (start) begin
                    x0_n    = x0;
                    y0_n    = y0;
                    w_n     = w;
                    h_n     = h;
                    color_n = color;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                eff_w_n    = eff_w_calc;
                eff_h_n    = eff_h_calc;
                col_n      = '0;
                row_n      = '0;
                // Constant-coefficient product, evaluated once per command.
                row_base_n = AW'(y0_q) * AW'(H_RES);
                if ((eff_w_calc == '0) || (eff_h_calc == '0)) begin
                    state_n = DONE;
                end else begin
                    state_n = FILL;
                end
            end
            FILL: begin
                if (col == eff_w_q - CW'(1)) begin
                    col_n = '0;
                    if (row == eff_h_q - CW'(1)) begin
                        state_n = DONE;
                    end else begin
                        row_n      = row + CW'(1);
                        row_base_n = row_base + AW'(H_RES);
                    end
                end else begin
                    col_n = col + CW'(1);
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Outputs are computed from the next state so they leave the register aligned with it.
        buf_we_n = (state_n == FILL);
        busy_n   = (state_n != IDLE);
        done_n   = (state_n == DONE);
        if (buf_we_n) begin
            buf_addr_n = row_base_n + AW'(x0_q) + AW'(col_n);
            buf_data_n = color_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            color_q  <= '0;
            eff_w_q  <= '0;
            eff_h_q  <= '0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            buf_addr <= '0;
            buf_data <= '0;
            buf_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            x0_q     <= x0_n;
            y0_q     <= y0_n;
            w_q      <= w_n;
            h_q      <= h_n;
            color_q  <= color_n;
            eff_w_q  <= eff_w_n;
            eff_h_q  <= eff_h_n;
            col      <= col_n;
            row      <= row_n;
            row_base <= row_base_n;
            buf_addr <= buf_addr_n;
            buf_data <= buf_data_n;
            buf_we   <= buf_we_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule
